// File: rtl/write_queue_decoder_if.sv
// Bundle for write_queue_decoder: write request handshake, the dequeue stall,
// the wordline/data output bus and the occupancy/scoreboard outputs.
interface write_queue_decoder_if #(
   parameter int ID_W   = 4,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
);
   localparam int NREG = 1 << ID_W;
   localparam int CW   = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [ID_W-1:0]   in_id;
   logic [DATA_W-1:0] in_data;
   logic              stall;
   logic [NREG-1:0]   Wordline;
   logic [DATA_W-1:0] WriteData;
   logic [NREG-1:0]   pending;
   logic [CW-1:0]     count;

   modport master (
      output in_valid, in_id, in_data, stall,
      input  in_ready, Wordline, WriteData, pending, count
   );

   modport slave (
      input  in_valid, in_id, in_data, stall,
      output in_ready, Wordline, WriteData, pending, count
   );
endinterface

// File: rtl/write_queue_decoder.sv
// Register write queue: FIFO of {id, data} drained one per cycle onto a registered
// one-hot wordline bus, with a per-register pending mask. Macro ZERO_REG_EN hard-wires register 0.
module write_queue_decoder #(
   parameter int ID_W   = 4,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   write_queue_decoder_if.slave bus
);
   localparam int NREG = 1 << ID_W;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;

   function automatic logic [NREG-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NREG-1:0] r;
      r     = '0;
      r[id] = 1'b1;
      return r;
   endfunction

   logic [ID_W-1:0]   mem_id_q   [DEPTH];
   logic [DATA_W-1:0] mem_data_q [DEPTH];

   logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [NREG-1:0]   wordline_q, wordline_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [CW-1:0]     count_w;
   logic              full_w, empty_w;
   logic              ready_w, enq_w, store_w, deq_w;
   logic [NREG-1:0]   pending_w;
   logic [ID_W-1:0]   head_id_w;
   logic [DATA_W-1:0] head_data_w;

   // Extra pointer bit separates full from empty; subtraction wraps modulo 2*DEPTH.
   assign count_w = wr_ptr_q - rd_ptr_q;
   assign full_w  = (count_w == CW'(DEPTH));
   assign empty_w = (count_w == '0);

   assign ready_w = !full_w && rst_n;
   assign enq_w   = bus.in_valid && ready_w;
   assign deq_w   = !empty_w && !bus.stall;

`ifdef ZERO_REG_EN
   assign store_w = enq_w && (bus.in_id != '0);
`else
   assign store_w = enq_w;
`endif

   assign head_id_w   = mem_id_q[rd_ptr_q[PW-1:0]];
   assign head_data_w = mem_data_q[rd_ptr_q[PW-1:0]];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      wordline_d = '0;
      wdata_d    = wdata_q;
      if (store_w) begin
         wr_ptr_d = wr_ptr_q + CW'(1);
      end
      if (deq_w) begin
         rd_ptr_d   = rd_ptr_q + CW'(1);
         wordline_d = onehot(head_id_w);
         wdata_d    = head_data_w;
      end
   end

   always_comb begin
      pending_w = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CW'(k) < count_w) begin
            pending_w = pending_w | onehot(mem_id_q[rd_ptr_q[PW-1:0] + PW'(k)]);
         end
      end
   end

   // Storage is only written on an accepted request, which cannot happen in reset.
   always_ff @(posedge clk) begin
      if (store_w) begin
         mem_id_q[wr_ptr_q[PW-1:0]]   <= bus.in_id;
         mem_data_q[wr_ptr_q[PW-1:0]] <= bus.in_data;
      end
   end

   // Output register stage: wordline/data are valid the cycle after dequeue.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         wordline_q <= '0;
         wdata_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         wordline_q <= wordline_d;
         wdata_q    <= wdata_d;
      end
   end

   assign bus.in_ready  = ready_w;
   assign bus.Wordline  = wordline_q;
   assign bus.WriteData = wdata_q;
   assign bus.pending   = pending_w;
   assign bus.count     = count_w;
endmodule

// File: tb/tb_write_queue_decoder.sv
// Directed plus random bench for write_queue_decoder against a queue-based model.
module tb_write_queue_decoder;
   localparam int ID_W   = 4;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int NREG   = 1 << ID_W;
`ifdef ZERO_REG_EN
   localparam bit ZERO = 1'b1;
`else
   localparam bit ZERO = 1'b0;
`endif

   typedef struct {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   ent_t              mq[$];
   logic [NREG-1:0]   exp_wl;
   logic [DATA_W-1:0] exp_wd;

   write_queue_decoder_if #(.ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   write_queue_decoder #(.ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREG-1:0] model_pending();
      logic [NREG-1:0] p;
      p = '0;
      foreach (mq[i]) p[mq[i].id] = 1'b1;
      return p;
   endfunction

   // One clock of stimulus: drive, check ready, advance model across the edge, check outputs.
   task automatic step(input logic v, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                       input logic st, input logic rn);
      logic exp_ready, acc;
      bus.in_valid = v;
      bus.in_id    = id;
      bus.in_data  = d;
      bus.stall    = st;
      rst_n        = rn;
      #1;
      exp_ready = rn && (mq.size() < DEPTH);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      acc = v && exp_ready;
      @(posedge clk);
      if (!rn) begin
         mq.delete();
         exp_wl = '0;
         exp_wd = '0;
      end else begin
         exp_wl = '0;
         if (mq.size() > 0 && !st) begin
            exp_wl = NREG'(1) << mq[0].id;
            exp_wd = mq[0].data;
            void'(mq.pop_front());
         end
         if (acc && !(ZERO && id == '0)) mq.push_back('{id: id, data: d});
      end
      #1;
      chk("Wordline", 32'(bus.Wordline), 32'(exp_wl));
      chk("WriteData", 32'(bus.WriteData), 32'(exp_wd));
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("pending", 32'(bus.pending), 32'(model_pending()));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      exp_wl = '0;
      exp_wd = '0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_id    = '0;
      bus.in_data  = '0;
      bus.stall    = 1'b0;

      // Reset, with a request presented that must be dropped
      step(1'b1, 4'd3, 16'h1234, 1'b0, 1'b0);
      step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
      chk("rst_count", 32'(bus.count), 32'd0);

      // Single write id=5
      step(1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b1);
      chk("beef_pending", 32'(bus.pending), 32'h0020);
      step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
      chk("beef_wl", 32'(bus.Wordline), 32'h0020);
      chk("beef_wd", 32'(bus.WriteData), 32'hBEEF);
      chk("beef_pend_clr", 32'(bus.pending), 32'h0000);
      step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
      chk("beef_wl_off", 32'(bus.Wordline), 32'h0000);

      // Fill under stall, overflow held, then drain
      for (int i = 1; i <= 4; i++) step(1'b1, ID_W'(i), 16'(16'hA000 + i), 1'b1, 1'b1);
      chk("full_count", 32'(bus.count), 32'd4);
      chk("full_pending", 32'(bus.pending), 32'h001E);
      step(1'b1, 4'd9, 16'h9999, 1'b1, 1'b1);
      step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
      chk("drain_wl0", 32'(bus.Wordline), 32'h0002);
      for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);

      // Same register twice, stall for 3 cycles
      step(1'b1, 4'd7, 16'h1111, 1'b1, 1'b1);
      step(1'b1, 4'd7, 16'h2222, 1'b1, 1'b1);
      step(1'b0, 4'd0, 16'h0000, 1'b1, 1'b1);
      step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
      chk("dup_wd1", 32'(bus.WriteData), 32'h1111);
      chk("dup_pend", 32'(bus.pending), 32'h0080);
      step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
      chk("dup_wd2", 32'(bus.WriteData), 32'h2222);
      chk("dup_pend_clr", 32'(bus.pending), 32'h0000);

      // Full queue with in_valid held high and no stall
      for (int i = 0; i < 4; i++) step(1'b1, ID_W'(i + 8), 16'($urandom), 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, ID_W'($urandom_range(1, NREG - 1)), 16'($urandom), 1'b0, 1'b1);
      chk("steady_count", 32'(bus.count), 32'd3);
      for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);

      // Reset with 3 entries queued; none may fire afterwards
      for (int i = 0; i < 3; i++) step(1'b1, ID_W'(i + 2), 16'($urandom), 1'b1, 1'b1);
      step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
      chk("rst3_count", 32'(bus.count), 32'd0);
      chk("rst3_pending", 32'(bus.pending), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);

      // Register 0
      step(1'b1, 4'd0, 16'hABCD, 1'b0, 1'b1);
      step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
      chk("zero_wl", 32'(bus.Wordline), ZERO ? 32'h0000 : 32'h0001);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'b1 & ($urandom_range(0, 3) != 0), ID_W'($urandom), 16'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) != 0));
      end
      for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
